mux4_rr_sched: RTL and testbench

//  Round-robin scheduler that shares the 4:1 8-bit pixel mux between four requesters
//  (e.g. left/right line buffers, census and cost units) feeding one downstream stage.

---
 rtl/mux4_rr_sched.sv | 110 +++++++++++
 tb/tb_mux4_rr_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sched.sv
`default_nettype none
// mux4_rr_sched: round-robin owner of the shared 4:1 pixel mux. It holds a grant for a
// bounded burst, then inserts one idle bubble before it arbitrates again.
module mux4_rr_sched #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] req_in,
  input  logic       ready_in,
  output logic [1:0] sel_out,
  output logic [3:0] grant_out,
  output logic       valid_out,
  output logic [3:0] ack_out,
  output logic       burst_done_out
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             transfer;
  logic             found;
  logic [1:0]       pick;

  assign valid_out      = (state_q == GRANT) & req_in[sel_q];
  assign transfer       = valid_out & ready_in;
  assign ack_out        = grant_q & {4{transfer}};
  assign sel_out        = sel_q;
  assign grant_out      = grant_q;
  assign burst_done_out = done_q;

  // The first set request wins. The scan starts at ptr and wraps modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && req_in[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          grant_d = 4'b0001 << pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (transfer) begin
          cnt_d = cnt_q + 1'b1;
        end
        if ((transfer && cnt_q == LAST_BEAT) || !req_in[sel_q]) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      grant_q <= 4'b0000;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
`default_nettype none
// tb_mux4_rr_sched: directed, self-checking scenarios for the round-robin mux scheduler.
// Inputs change on the falling edge, and outputs are sampled 1 ns after that edge.
module tb_mux4_rr_sched;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [3:0] req_in = 4'b0000;
  logic       ready_in = 1'b0;
  logic [1:0] sel_out;
  logic [3:0] grant_out;
  logic       valid_out;
  logic [3:0] ack_out;
  logic       burst_done_out;

  int n_tests = 0;
  int n_fail  = 0;

  mux4_rr_sched #(.BURST_LEN(16), .CNT_W(5)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_in        (req_in),
    .ready_in      (ready_in),
    .sel_out       (sel_out),
    .grant_out     (grant_out),
    .valid_out     (valid_out),
    .ack_out       (ack_out),
    .burst_done_out(burst_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    req_in   = 4'b0000;
    ready_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    req_in   = 4'hF;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      #1;
      n_tests++;
      if (grant_out !== 4'b0000 || sel_out !== 2'd0 || valid_out !== 1'b0 ||
          ack_out !== 4'b0000 || burst_done_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: grant=%b sel=%0d valid=%b ack=%b done=%b, want 0000/0/0/0000/0",
                 grant_out, sel_out, valid_out, ack_out, burst_done_out);
      end
    end
    rst_n_in = 1'b1;
  endtask

  task automatic test_single();
    int acks = 0;
    apply_reset();
    req_in   = 4'b0100;
    ready_in = 1'b1;
    #1;
    n_tests++;
    if (grant_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: grant=%b want 0000", grant_out);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      #1;
      n_tests++;
      if (grant_out !== 4'b0100 || sel_out !== 2'd2 || ack_out !== 4'b0100 ||
          burst_done_out !== 1'b0) begin
        n_fail++;
        $display("FAIL single_beat%0d: grant=%b sel=%0d ack=%b done=%b want 0100/2/0100/0",
                 i, grant_out, sel_out, ack_out, burst_done_out);
      end else begin
        acks++;
      end
    end
    n_tests++;
    if (acks != 16) begin
      n_fail++;
      $display("FAIL single_acks: got %0d want 16", acks);
    end
    @(negedge clk_in);
    #1;
    n_tests++;
    if (burst_done_out !== 1'b1 || grant_out !== 4'b0000 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_bubble: done=%b grant=%b valid=%b want 1/0000/0",
               burst_done_out, grant_out, valid_out);
    end
    @(negedge clk_in);
    #1;
    n_tests++;
    if (grant_out !== 4'b0100 || sel_out !== 2'd2 || burst_done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_regrant: grant=%b sel=%0d done=%b want 0100/2/0",
               grant_out, sel_out, burst_done_out);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] g_exp;
    apply_reset();
    req_in   = 4'hF;
    ready_in = 1'b1;
    for (int g = 0; g < 5; g++) begin
      g_exp = 4'b0001 << order[g];
      for (int i = 0; i < 16; i++) begin
        @(negedge clk_in);
        #1;
        if (i == 0 || i == 15) begin
          n_tests++;
          if (grant_out !== g_exp || sel_out !== order[g] || ack_out !== g_exp) begin
            n_fail++;
            $display("FAIL fair_g%0d_b%0d: grant=%b sel=%0d ack=%b want %b/%0d/%b",
                     g, i, grant_out, sel_out, ack_out, g_exp, order[g], g_exp);
          end
        end
      end
      @(negedge clk_in);
      #1;
      n_tests++;
      if (grant_out !== 4'b0000 || burst_done_out !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_bubble%0d: grant=%b done=%b want 0000/1",
                 g, grant_out, burst_done_out);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    int accepted = 0;
    int k = 0;
    apply_reset();
    req_in   = 4'b0010;
    ready_in = 1'b0;
    while (accepted < 16 && k < 100) begin
      @(negedge clk_in);
      ready_in = pat[k % 4];
      #1;
      n_tests++;
      if (grant_out !== 4'b0010 || valid_out !== 1'b1 ||
          ack_out !== (ready_in ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: grant=%b valid=%b ack=%b want 0010/1/%b",
                 k, grant_out, valid_out, ack_out, ready_in ? 4'b0010 : 4'b0000);
      end
      if (ready_in) accepted++;
      k++;
    end
    n_tests++;
    if (k != 32) begin
      n_fail++;
      $display("FAIL bp_cycles: got %0d cycles want 32", k);
    end
    @(negedge clk_in);
    #1;
    n_tests++;
    if (grant_out !== 4'b0000 || burst_done_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: grant=%b done=%b want 0000/1", grant_out, burst_done_out);
    end
  endtask

  task automatic test_early_drop();
    apply_reset();
    req_in   = 4'b1000;
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      #1;
      n_tests++;
      if (grant_out !== 4'b1000 || sel_out !== 2'd3 || ack_out !== 4'b1000) begin
        n_fail++;
        $display("FAIL drop_beat%0d: grant=%b sel=%0d ack=%b want 1000/3/1000",
                 i, grant_out, sel_out, ack_out);
      end
    end
    @(negedge clk_in);
    req_in = 4'b0011;
    #1;
    n_tests++;
    if (grant_out !== 4'b1000 || valid_out !== 1'b0 || ack_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_fall: grant=%b valid=%b ack=%b want 1000/0/0000",
               grant_out, valid_out, ack_out);
    end
    @(negedge clk_in);
    #1;
    n_tests++;
    if (grant_out !== 4'b0000 || burst_done_out !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_release: grant=%b done=%b want 0000/1", grant_out, burst_done_out);
    end
    @(negedge clk_in);
    #1;
    n_tests++;
    if (grant_out !== 4'b0001 || sel_out !== 2'd0 || burst_done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_next: grant=%b sel=%0d done=%b want 0001/0/0",
               grant_out, sel_out, burst_done_out);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req_in   = 4'b0001;
    ready_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    req_in = 4'b0010;
    @(negedge clk_in);
    @(negedge clk_in);
    req_in = 4'b0011;
    #1;
    n_tests++;
    if (grant_out !== 4'b0010 || sel_out !== 2'd1) begin
      n_fail++;
      $display("FAIL mr_setup: grant=%b sel=%0d want 0010/1", grant_out, sel_out);
    end
    for (int i = 1; i < 7; i++) begin
      @(negedge clk_in);
    end
    #1;
    n_tests++;
    if (ack_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL mr_beat7: ack=%b want 0010", ack_out);
    end
    #1;
    rst_n_in = 1'b0;
    #1;
    n_tests++;
    if (grant_out !== 4'b0000 || sel_out !== 2'd0 || valid_out !== 1'b0 ||
        ack_out !== 4'b0000 || burst_done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_async: grant=%b sel=%0d valid=%b ack=%b done=%b want 0000/0/0/0000/0",
               grant_out, sel_out, valid_out, ack_out, burst_done_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    #1;
    n_tests++;
    if (grant_out !== 4'b0001 || sel_out !== 2'd0) begin
      n_fail++;
      $display("FAIL mr_restart: grant=%b sel=%0d want 0001/0", grant_out, sel_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_drop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
